// File: rtl/eth_tx_pkg.sv
// Shared types, constants and helper functions for the AXI-Stream to GMII
// frame transmitter.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        PAYLOAD  = 3'd2,
        PAD      = 3'd3,
        FCS      = 3'd4,
        DROP     = 3'd5,
        IFG      = 3'd6
    } tx_state_e;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC32_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// One-byte step of the Ethernet CRC-32 (reflected, 0xEDB88320).
module eth_crc32_d8
    import eth_tx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_byte(crc_i, data_i);

endmodule

// File: rtl/eth_axis_gmii_tx.sv
// AXI-Stream to GMII transmitter: adds preamble/SFD, pads short frames,
// appends the FCS and enforces the inter-frame gap.
module eth_axis_gmii_tx
    import eth_tx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_BYTES     = 12
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       gmii_tx_er_o,
    output logic       busy_o
);

    localparam logic [15:0] MIN_LEN_C    = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] IFG_LAST_C   = 16'((IFG_BYTES > 0) ? (IFG_BYTES - 1) : 0);
    localparam tx_state_e   POST_FRAME_C = (IFG_BYTES > 0) ? IFG : IDLE;

    tx_state_e   state_r;
    tx_state_e   state_nxt_s;
    logic [15:0] step_r;
    logic [15:0] step_nxt_s;
    logic [15:0] pay_cnt_r;
    logic [15:0] pay_cnt_nxt_s;
    logic [15:0] pay_cnt_inc_s;
    logic [31:0] crc_r;
    logic [31:0] crc_nxt_s;
    logic [31:0] crc_calc_s;
    logic [31:0] fcs_s;
    logic [7:0]  crc_data_s;
    logic [7:0]  txd_r;
    logic [7:0]  txd_nxt_s;
    logic        tx_en_r;
    logic        tx_en_nxt_s;
    logic        tx_er_r;
    logic        tx_er_nxt_s;
    logic        tready_r;
    logic        busy_r;

    assign pay_cnt_inc_s = sat_inc16(pay_cnt_r);
    assign fcs_s         = ~crc_r;

    // Pad bytes feed zeros into the CRC; everything else feeds the stream byte
    always_comb begin
        if (state_r == PAD) begin
            crc_data_s = 8'h00;
        end else begin
            crc_data_s = s_axis_tdata;
        end
    end

    eth_crc32_d8 u_crc (
        .crc_i  (crc_r),
        .data_i (crc_data_s),
        .crc_o  (crc_calc_s)
    );

    // Next-state, counter, CRC and next output byte decode
    always_comb begin
        state_nxt_s   = state_r;
        step_nxt_s    = step_r;
        pay_cnt_nxt_s = pay_cnt_r;
        crc_nxt_s     = crc_r;
        txd_nxt_s     = 8'h00;
        tx_en_nxt_s   = 1'b0;
        tx_er_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_axis_tvalid) begin
                    state_nxt_s = PREAMBLE;
                    step_nxt_s  = 16'd0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PREAMBLE: begin
                tx_en_nxt_s   = 1'b1;
                pay_cnt_nxt_s = 16'd0;
                crc_nxt_s     = CRC32_INIT;
                if (step_r == 16'd7) begin
                    txd_nxt_s   = ETH_SFD;
                    state_nxt_s = PAYLOAD;
                    step_nxt_s  = 16'd0;
                end else begin
                    txd_nxt_s  = ETH_PREAMBLE;
                    step_nxt_s = step_r + 16'd1;
                end
            end
            PAYLOAD: begin
                tx_en_nxt_s = 1'b1;
                if (s_axis_tvalid) begin
                    txd_nxt_s     = s_axis_tdata;
                    tx_er_nxt_s   = s_axis_tuser;
                    crc_nxt_s     = crc_calc_s;
                    pay_cnt_nxt_s = pay_cnt_inc_s;
                    if (s_axis_tlast) begin
                        step_nxt_s = 16'd0;
                        if (pay_cnt_inc_s < MIN_LEN_C) begin
                            state_nxt_s = PAD;
                        end else begin
                            state_nxt_s = FCS;
                        end
                    end else begin
                        state_nxt_s = PAYLOAD;
                    end
                end else begin
                    // Source starved mid-frame: flag the error once, then swallow the rest
                    tx_er_nxt_s = 1'b1;
                    state_nxt_s = DROP;
                end
            end
            PAD: begin
                tx_en_nxt_s   = 1'b1;
                crc_nxt_s     = crc_calc_s;
                pay_cnt_nxt_s = pay_cnt_inc_s;
                if (pay_cnt_inc_s >= MIN_LEN_C) begin
                    state_nxt_s = FCS;
                    step_nxt_s  = 16'd0;
                end else begin
                    state_nxt_s = PAD;
                end
            end
            FCS: begin
                tx_en_nxt_s = 1'b1;
                case (step_r[1:0])
                    2'd0:    txd_nxt_s = fcs_s[7:0];
                    2'd1:    txd_nxt_s = fcs_s[15:8];
                    2'd2:    txd_nxt_s = fcs_s[23:16];
                    default: txd_nxt_s = fcs_s[31:24];
                endcase
                if (step_r == 16'd3) begin
                    state_nxt_s = POST_FRAME_C;
                    step_nxt_s  = 16'd0;
                end else begin
                    step_nxt_s = step_r + 16'd1;
                end
            end
            DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_nxt_s = POST_FRAME_C;
                    step_nxt_s  = 16'd0;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            IFG: begin
                if (step_r >= IFG_LAST_C) begin
                    step_nxt_s = 16'd0;
                    if (s_axis_tvalid) begin
                        state_nxt_s = PREAMBLE;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    step_nxt_s = step_r + 16'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                step_nxt_s  = 16'd0;
            end
        endcase
    end

    // FSM state, byte counters and running CRC
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            step_r    <= 16'd0;
            pay_cnt_r <= 16'd0;
            crc_r     <= CRC32_INIT;
        end else begin
            state_r   <= state_nxt_s;
            step_r    <= step_nxt_s;
            pay_cnt_r <= pay_cnt_nxt_s;
            crc_r     <= crc_nxt_s;
        end
    end

    // Registered GMII outputs plus ready/busy decoded from the upcoming state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            txd_r    <= 8'h00;
            tx_en_r  <= 1'b0;
            tx_er_r  <= 1'b0;
            tready_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            txd_r    <= txd_nxt_s;
            tx_en_r  <= tx_en_nxt_s;
            tx_er_r  <= tx_er_nxt_s;
            tready_r <= (state_nxt_s == PAYLOAD) || (state_nxt_s == DROP);
            busy_r   <= (state_nxt_s != IDLE);
        end
    end

    assign gmii_txd_o    = txd_r;
    assign gmii_tx_en_o  = tx_en_r;
    assign gmii_tx_er_o  = tx_er_r;
    assign s_axis_tready = tready_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_eth_axis_gmii_tx.sv
// Self-checking bench: table-driven frames, hand-written corner sequences and
// random frames against a frame-level reference model.
module tb_eth_axis_gmii_tx;

    typedef logic [7:0] bq_t[$];
    typedef logic [8:0] wq_t[$];
    typedef struct {
        int idx;
        int len;
        int fill;
        int err_at;
        int gap_at;
        int exp_en;
        int exp_er;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tdata [2];
    logic       tvalid[2];
    logic       tlast [2];
    logic       tuser [2];
    logic       tready[2];
    logic [7:0] txd   [2];
    logic       tx_en [2];
    logic       tx_er [2];
    logic       busy  [2];

    int  tests = 0;
    int  fails = 0;
    wq_t cap_q[2];
    int  runs_q[2][$];
    int  gaps_q[2][$];
    int  run_len[2];
    int  gap_len[2];
    bit  had_run[2];

    always #5 clk = ~clk;

    eth_axis_gmii_tx dut0 (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
        .s_axis_tlast(tlast[0]), .s_axis_tuser(tuser[0]),
        .gmii_txd_o(txd[0]), .gmii_tx_en_o(tx_en[0]), .gmii_tx_er_o(tx_er[0]), .busy_o(busy[0])
    );

    eth_axis_gmii_tx #(.MIN_FRAME_LEN(0), .IFG_BYTES(12)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
        .s_axis_tlast(tlast[1]), .s_axis_tuser(tuser[1]),
        .gmii_txd_o(txd[1]), .gmii_tx_en_o(tx_en[1]), .gmii_tx_er_o(tx_er[1]), .busy_o(busy[1])
    );

    // Output monitor: collects tx_en-high bytes, run lengths and gap lengths
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cap_q[i].delete();
                runs_q[i].delete();
                run_len[i] = 0;
                gap_len[i] = 0;
                had_run[i] = 1'b0;
            end else if (tx_en[i]) begin
                if (run_len[i] == 0 && had_run[i]) gaps_q[i].push_back(gap_len[i]);
                cap_q[i].push_back({tx_er[i], txd[i]});
                run_len[i]++;
            end else begin
                if (run_len[i] > 0) begin
                    runs_q[i].push_back(run_len[i]);
                    run_len[i] = 0;
                    had_run[i] = 1'b1;
                    gap_len[i] = 0;
                end
                gap_len[i]++;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Reference: whole frame as seen on GMII (er bit + byte per tx_en cycle)
    function automatic void model(input bq_t data, input int min_len, input int err_at,
                                  input int gap_at, output wq_t exp);
        bq_t         frame;
        logic [31:0] crc;
        logic [31:0] fcs;
        logic        fb;
        exp = {};
        for (int k = 0; k < 7; k++) exp.push_back(9'h055);
        exp.push_back(9'h0D5);
        if (gap_at >= 0) begin
            for (int k = 0; k < gap_at; k++) exp.push_back({(k == err_at), data[k]});
            exp.push_back(9'h100);
        end else begin
            frame = data;
            while (frame.size() < min_len) frame.push_back(8'h00);
            crc = 32'hFFFFFFFF;
            foreach (frame[k]) begin
                for (int b = 0; b < 8; b++) begin
                    fb  = crc[0] ^ frame[k][b];
                    crc = crc >> 1;
                    if (fb) crc = crc ^ 32'hEDB88320;
                end
            end
            foreach (frame[k]) exp.push_back({(k == err_at), frame[k]});
            fcs = ~crc;
            for (int b = 0; b < 4; b++) exp.push_back({1'b0, fcs[8*b +: 8]});
        end
    endfunction

    task automatic send_frame(input int idx, input bq_t data, input int err_at, input int gap_at);
        int guard;
        for (int k = 0; k < data.size(); k++) begin
            if (k == gap_at) begin
                tvalid[idx] = 1'b0;
                @(posedge clk);
                #1;
            end
            tdata[idx]  = data[k];
            tlast[idx]  = (k == data.size() - 1);
            tuser[idx]  = (k == err_at);
            tvalid[idx] = 1'b1;
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!tready[idx] && guard < 3000);
            if (!tready[idx]) begin
                tests++;
                fails++;
                $display("FAIL handshake_timeout: idx %0d byte %0d tready=0, expected 1", idx, k);
                tvalid[idx] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tvalid[idx] = 1'b0;
        tlast[idx]  = 1'b0;
        tuser[idx]  = 1'b0;
    endtask

    task automatic compare_run(input string name, input int idx, input wq_t want,
                               input int exp_en, input int exp_er);
        int         g;
        int         len;
        int         ers;
        int         bad;
        logic [8:0] w;
        g = 0;
        while (runs_q[idx].size() == 0 && g < 5000) begin
            @(negedge clk);
            #1;
            g++;
        end
        if (runs_q[idx].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no completed tx_en burst on idx %0d", name, idx);
            return;
        end
        len = runs_q[idx].pop_front();
        check({name, "_len"}, len, want.size());
        if (exp_en >= 0) check({name, "_en_cycles"}, len, exp_en);
        ers = 0;
        bad = -1;
        for (int k = 0; k < len; k++) begin
            w = (cap_q[idx].size() > 0) ? cap_q[idx].pop_front() : 9'h1FF;
            ers += int'(w[8]);
            if (bad < 0 && (k >= want.size() || w !== want[k])) bad = k;
        end
        if (exp_er >= 0) check({name, "_er_cycles"}, ers, exp_er);
        check({name, "_first_bad_byte_index"}, bad, -1);
    endtask

    task automatic check_frame(input string name, input int idx, input bq_t data, input int err_at,
                               input int gap_at, input int exp_en, input int exp_er);
        wq_t exp;
        model(data, (idx == 0) ? 60 : 0, err_at, gap_at, exp);
        compare_run(name, idx, exp, exp_en, exp_er);
    endtask

    initial begin
        vec_t vecs[$];
        bq_t  data;
        bq_t  data2;
        wq_t  want;
        int   idx, len, err, gap, g, n, rdy;

        for (int i = 0; i < 2; i++) begin
            tdata[i] = 8'h00; tvalid[i] = 1'b0; tlast[i] = 1'b0; tuser[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("reset_outputs", {txd[i], tx_en[i], tx_er[i], tready[i], busy[i]}, 0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // 9-byte check frame with padding disabled, against literal bytes
        data = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        want = {};
        for (int k = 0; k < 7; k++) want.push_back(9'h055);
        want.push_back(9'h0D5);
        foreach (data[k]) want.push_back({1'b0, data[k]});
        want.push_back(9'h026); want.push_back(9'h039); want.push_back(9'h0F4); want.push_back(9'h0CB);
        send_frame(1, data, -1, -1);
        compare_run("crc_check_123456789", 1, want, 21, 0);

        // idx, len, fill, err_at, gap_at, exp_en, exp_er
        vecs.push_back('{0,   1, 8'hAB, -1, -1,  72, 0});
        vecs.push_back('{0,  20,    -1, -1,  5,  14, 1});
        vecs.push_back('{0,  20,    -1,  3, -1,  72, 1});
        vecs.push_back('{0,  59,    -1, -1, -1,  72, 0});
        vecs.push_back('{0,  60,    -1, -1, -1,  72, 0});
        vecs.push_back('{0,  61,    -1, -1, -1,  73, 0});
        vecs.push_back('{0, 100,    -1,  7, -1, 112, 1});
        vecs.push_back('{1,   1,    -1, -1, -1,  13, 0});
        vecs.push_back('{1,  30,    -1, -1, 29,  38, 1});
        vecs.push_back('{1,  12,    -1,  0, -1,  24, 1});
        foreach (vecs[v]) begin
            data = {};
            for (int k = 0; k < vecs[v].len; k++)
                data.push_back((vecs[v].fill >= 0) ? 8'(vecs[v].fill + k) : 8'($urandom_range(0, 255)));
            send_frame(vecs[v].idx, data, vecs[v].err_at, vecs[v].gap_at);
            check_frame($sformatf("vec%0d", v), vecs[v].idx, data, vecs[v].err_at,
                        vecs[v].gap_at, vecs[v].exp_en, vecs[v].exp_er);
        end

        // Back-to-back frames with tvalid held: exact gap and ready held low
        data  = {8'hAB};
        data2 = {8'h11, 8'h22};
        fork
            begin
                send_frame(0, data, -1, -1);
                send_frame(0, data2, -1, -1);
            end
            begin
                g = 0;
                while (!tx_en[0] && g < 500) begin @(negedge clk); g++; end
                while (tx_en[0] && g < 1000) begin @(negedge clk); g++; end
                rdy = 0;
                for (int k = 0; k < 19; k++) begin
                    rdy += int'(tready[0]);
                    @(negedge clk);
                end
                check("b2b_tready_during_gap_and_preamble", rdy, 0);
                check("b2b_tready_at_payload", tready[0], 1);
            end
        join
        check_frame("b2b_frame1", 0, data, -1, -1, 72, 0);
        check_frame("b2b_frame2", 0, data2, -1, -1, 72, 0);
        check("b2b_gap_cycles", (gaps_q[0].size() > 0) ? gaps_q[0].pop_back() : -1, 12);

        // Reset pulsed while the second FCS byte is on the wire
        data = {8'h5A};
        fork
            send_frame(0, data, -1, -1);
            begin
                g = 0;
                n = 0;
                while (n < 70 && g < 1000) begin
                    @(negedge clk);
                    g++;
                    if (tx_en[0]) n++;
                end
                check("fcs_byte2_reached", n, 70);
                #2 rst = 1'b1;
                #1;
                check("midframe_reset_outputs", {txd[0], tx_en[0], tx_er[0], tready[0], busy[0]}, 0);
                @(posedge clk);
                @(negedge clk);
                #2 rst = 1'b0;
            end
        join
        data = {};
        for (int k = 0; k < 10; k++) data.push_back(8'($urandom_range(0, 255)));
        fork
            send_frame(0, data, -1, -1);
            begin
                n = 0;
                while (!tx_en[0] && n < 100) begin @(negedge clk); n++; end
                check("post_reset_start_latency", n, 2);
            end
        join
        check_frame("post_reset_frame", 0, data, -1, -1, 72, 0);

        // Random frames against the reference model
        for (int r = 0; r < 30; r++) begin
            idx = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 90));
            if ($urandom_range(0, 3) == 0) err = int'($urandom_range(0, len - 1));
            else err = -1;
            if (len > 1 && $urandom_range(0, 4) == 0) gap = int'($urandom_range(1, len - 1));
            else gap = -1;
            data = {};
            for (int k = 0; k < len; k++) data.push_back(8'($urandom_range(0, 255)));
            send_frame(idx, data, err, gap);
            check_frame($sformatf("rand%0d", r), idx, data, err, gap, -1, -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_axis_gmii_tx.md
ETH_AXIS_GMII_TX -- requirements
Module: eth_axis_gmii_tx

Interface
REQ-001 SHALL have parameter MIN_FRAME_LEN, default 60, giving the minimum payload byte count before FCS; 0 disables padding.
REQ-002 SHALL have parameter IFG_BYTES, default 12, giving the idle cycles enforced after each frame.
REQ-003 SHALL have a single clock domain; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  byte clock; all logic is on the rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 s_axis_tdata  input  8  payload byte (destination MAC onward, no FCS).
REQ-007 s_axis_tvalid  input  1  byte valid.
REQ-008 s_axis_tready  output  1  byte accepted when tvalid and tready are both high.
REQ-009 s_axis_tlast  input  1  last payload byte of the frame.
REQ-010 s_axis_tuser  input  1  error mark on the accompanying byte.
REQ-011 gmii_txd_o  output  8  transmit byte.
REQ-012 gmii_tx_en_o  output  1  frame-active strobe.
REQ-013 gmii_tx_er_o  output  1  transmit error strobe.
REQ-014 busy_o  output  1  high in every state except IDLE.

Function
REQ-015 SHALL register all gmii_* outputs; a byte accepted in cycle N appears on gmii_txd_o in cycle N+1.
REQ-016 SHALL use FSM states IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DROP and IFG.
- IDLE→PREAMBLE: on s_axis_tvalid.
- PREAMBLE→PAYLOAD: after 8 bytes.
- PAYLOAD→PAD: on accepted tlast when count < MIN_FRAME_LEN.
- PAYLOAD→FCS: on accepted tlast otherwise.
- PAD→FCS: when count reaches MIN_FRAME_LEN.
- FCS→IFG: after 4 bytes.
- IFG→IDLE: after IFG_BYTES cycles.
REQ-017 In PREAMBLE, SHALL emit 0x55 seven times and then 0xD5 (SFD), with tx_en=1 and tready=0.
REQ-018 SHALL drive s_axis_tready high only in PAYLOAD and DROP.
REQ-019 SHALL count payload bytes with a 16-bit counter that saturates at 0xFFFF and never wraps.
REQ-020 In PAD, SHALL emit 0x00 bytes, which are included in the CRC.
REQ-021 SHALL compute the CRC-32 over payload and pad bytes, excluding preamble and SFD.
- Reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
- FCS is the complemented CRC, sent LSB byte first.
REQ-022 SHALL assert gmii_tx_er_o, with tx_en=1, for any byte accepted with s_axis_tuser=1, and SHALL continue the frame.
REQ-023 Underflow (tvalid low in PAYLOAD) SHALL assert tx_er for one cycle and then enter DROP.
REQ-024 In DROP, SHALL keep tx_en=0 and tready=1, discard bytes until an accepted tlast, then enter IFG (no FCS sent).
REQ-025 In IFG, SHALL drive tx_en=0, tx_er=0 and txd=0x00.
REQ-026 SHALL ignore s_axis_tvalid during IFG; a frame pending at IFG end SHALL enter PREAMBLE with no extra idle cycle.
REQ-027 A tlast on the first payload byte SHALL be valid (1-byte frame).

Reset
REQ-028 Reset SHALL force state IDLE, gmii_txd_o=0x00, gmii_tx_en_o=0, gmii_tx_er_o=0, s_axis_tready=0, busy_o=0, counters=0 and CRC=0xFFFFFFFF.
REQ-029 Reset asserted mid-frame SHALL truncate the frame immediately, with no FCS and no tx_er.
REQ-030 The first frame after reset release SHALL start without an IFG.

Structure
REQ-031 Package eth_tx_pkg SHALL hold:
- FSM state enum.
- Constants ETH_PREAMBLE=0x55, ETH_SFD=0xD5, CRC32_POLY=0xEDB88320, CRC32_INIT=0xFFFFFFFF.
REQ-032 Combinational sub-module eth_crc32_d8 SHALL provide the 8-bit-per-step CRC update: crc_i[31:0], data_i[7:0] → crc_o[31:0].

Verification
REQ-033 With MIN_FRAME_LEN=0, payload "123456789" (0x31..0x39) → output 55×7, D5, 31..39, then FCS 26 39 F4 CB; tx_en high for exactly 21 cycles.
REQ-034 Default parameters, 1-byte frame 0xAB → AB followed by 59×00 pad and 4 FCS bytes; tx_en high for 72 cycles; exactly 12 idle cycles before the next SFD.
REQ-035 Back-to-back frames with tvalid held high → gap between tx_en falling and rising is exactly 12 cycles; tready stays 0 during the gap and the preamble.
REQ-036 tvalid dropped at payload byte 5 of a 20-byte frame → one tx_er cycle, tx_en=0 afterwards, remaining bytes accepted and discarded, no FCS, then IFG.
REQ-037 tuser=1 on payload byte 3 → tx_er high for that single output byte; frame completes with a correct FCS.
REQ-038 rst_i pulsed during FCS byte 2 → all outputs reach reset values before the next edge; the next frame starts cleanly without IFG.
